// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: fetches sequential words from a combinational
// instruction memory into a small FIFO. Optional feature macro: PREFETCH_PERF_CNT_EN.
module instr_prefetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          MEM_WORDS = 16384,
  parameter logic [31:0] RESET_PC  = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  output logic [13:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] perf_fetch_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {FETCH, FAULTED} state_t;

  // Handshake: an entry transfers on a rising edge where out_valid && out_ready;
  // out_* hold steady while out_valid=1 and out_ready=0.

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] pc_q    [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic        fault_q [DEPTH];

  logic [31:0] offset;
  logic        fault;
  logic        push;
  logic        pop;

  assign offset    = fetch_pc - BASE_ADDR;
  assign imem_addr = offset[15:2];

  assign fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc < BASE_ADDR) ||
                 ({1'b0, fetch_pc} >= END_ADDR);

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : 32'h0;
  assign out_instr = out_valid ? instr_q[rd_ptr] : 32'h0;
  assign out_fault = out_valid ? fault_q[rd_ptr] : 1'b0;

  // A redirect suppresses both sides of the FIFO in its cycle.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = (state == FETCH) && !redirect_valid &&
                ((count < CW'(DEPTH)) || (out_valid && out_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      state    <= FETCH;
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fault) state <= FAULTED;
        else       fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= fetch_pc;
      instr_q[wr_ptr] <= fault ? NOP_INSTR : imem_rdata;
      fault_q[wr_ptr] <= fault;
    end
  end

`ifdef PREFETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_count <= 32'h0;
    end else if (push && !fault && (perf_fetch_count != 32'hFFFF_FFFF)) begin
      perf_fetch_count <= perf_fetch_count + 32'd1;
    end
  end
`else
  assign perf_fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed table-driven bench for instr_prefetch_buffer, plus hand sequences for
// mid-operation reset and the PREFETCH_PERF_CNT_EN counter.
module tb_instr_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] perf_fetch_count;

  logic [31:0] mem [16384];

  int vectors;
  int errors;

  instr_prefetch_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_instr        (out_instr),
    .out_fault        (out_fault),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .perf_fetch_count (perf_fetch_count)
  );

  assign imem_rdata = mem[imem_addr];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ef;
    logic        ca;
    logic [13:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic ef,
                              input logic ca, input logic [13:0] eaddr);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc;
    v.einstr = einstr; v.ef = ef; v.ca = ca; v.eaddr = eaddr;
    vecs.push_back(v);
  endfunction

  // Plain cycle with no redirect and no address check.
  function automatic void cyc(input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic ef);
    add(1'b0, 32'h0, rdy, ev, epc, einstr, ef, 1'b0, 14'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einstr, input logic ef);
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, ev});
    chk({tag, ".pc"},    out_pc, epc);
    chk({tag, ".instr"}, out_instr, einstr);
    chk({tag, ".fault"}, {31'h0, out_fault}, {31'h0, ef});
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;

    // Reset release and streaming with out_ready=1
    add(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 14'h0000);
    cyc(1'b1, 1'b1, 32'h0001_0000, 32'd11, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_0004, 32'd22, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_0008, 32'd33, 1'b0);
    // Stall for 10 cycles: head holds, FIFO fills to 4, fetch_pc stops at 0x1001C
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 32'h0001_000C, 32'd44, 1'b0);
    add(1'b0, 32'h0, 1'b0, 1'b1, 32'h0001_000C, 32'd44, 1'b0, 1'b1, 14'h0007);
    // Release: back-to-back pops, no gaps
    cyc(1'b1, 1'b1, 32'h0001_000C, 32'd44, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_0010, 32'hA000_0004, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_0014, 32'hA000_0005, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_0018, 32'hA000_0006, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_001C, 32'hA000_0007, 1'b0);
    // Redirect to 0x10100 while full and popping
    add(1'b1, 32'h0001_0100, 1'b1, 1'b1, 32'h0001_0020, 32'hA000_0008, 1'b0, 1'b0, 14'h0);
    add(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 14'h0040);
    cyc(1'b1, 1'b1, 32'h0001_0100, 32'hA000_0040, 1'b0);
    // Misaligned redirect: one fault entry, then silence
    add(1'b1, 32'h0001_0002, 1'b1, 1'b1, 32'h0001_0104, 32'hA000_0041, 1'b0, 1'b0, 14'h0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_0002, 32'h0000_0013, 1'b1);
    add(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 14'h0000);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    // Recovery by redirect to 0x10000
    add(1'b1, 32'h0001_0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 14'h0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_0000, 32'd11, 1'b0);
    // End of region
    add(1'b1, 32'h0001_FFF8, 1'b1, 1'b1, 32'h0001_0004, 32'd22, 1'b0, 1'b0, 14'h0);
    add(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 14'h3FFE);
    cyc(1'b1, 1'b1, 32'h0001_FFF8, 32'hA000_3FFE, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_FFFC, 32'hA000_3FFF, 1'b0);
    cyc(1'b1, 1'b1, 32'h0002_0000, 32'h0000_0013, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    add(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 14'h0000);

    // Reset state
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    #1;
    vectors++;
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("reset.perf", perf_fetch_count, 32'h0);
    chk("reset.addr", {18'h0, imem_addr}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      #1;
      vectors++;
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr, vecs[i].ef);
      if (vecs[i].ca) chk($sformatf("vec%0d.addr", i), {18'h0, imem_addr}, {18'h0, vecs[i].eaddr});
      @(negedge clk);
    end

    // Mid-operation reset discards entries asynchronously
    redirect_valid = 1'b1; redirect_pc = 32'h0001_0000; out_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    chk_out("prefill", 1'b1, 32'h0001_0000, 32'd11, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    chk_out("midreset", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("midreset.perf", perf_fetch_count, 32'h0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    chk_out("rerelease", 1'b1, 32'h0001_0000, 32'd11, 1'b0);
    @(negedge clk);

`ifdef PREFETCH_PERF_CNT_EN
    // 8 good fetches (0x1FFE0..0x1FFFC) then one fault
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0001_FFE0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    vectors++;
    chk("perf.count", perf_fetch_count, 32'd8);
    chk("perf.idle", {31'h0, out_valid}, 32'h0);
`else
    #1;
    vectors++;
    chk("perf.tied", perf_fetch_count, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
